hazard_ctrl: RTL

//  Hazard/sequencing controller for the 5-stage MIPS pipeline: detects load-use and mult/div hazards,

---
 rtl/hazard_ctrl_pkg.sv | 29 ++
 rtl/hazard_ctrl_if.sv | 51 +++++
 rtl/hazard_ctrl_fwd_sel.sv | 24 ++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int RA_W_DEF       = 5;
  localparam int MD_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF      = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_BUSY  = 2'd1,
    ST_MD_DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  // Pipeline hold/kill controls produced by the FSM output decode.
  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic bubble_ex;
    logic flush_id;
  } ctrl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The i_/o_ prefixes are
// relative to the controller: the pipeline (master) drives i_*, reads o_*.
interface hazard_ctrl_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
);
  logic [RA_W-1:0]  i_id_rs;
  logic [RA_W-1:0]  i_id_rt;
  logic             i_id_use_rs;
  logic             i_id_use_rt;
  logic [RA_W-1:0]  i_ex_rs;
  logic [RA_W-1:0]  i_ex_rt;
  logic [RA_W-1:0]  i_ex_rd;
  logic             i_ex_memread;
  logic             i_ex_muldiv;
  logic             i_branch_taken;
  logic [RA_W-1:0]  i_mem_rd;
  logic             i_mem_regwrite;
  logic [RA_W-1:0]  i_wb_rd;
  logic             i_wb_regwrite;
  logic             i_muldiv_done;
  logic             i_stat_clr;

  logic             o_stall_if;
  logic             o_stall_id;
  logic             o_stall_ex;
  logic             o_bubble_ex;
  logic             o_flush_id;
  logic [1:0]       o_fwd_a;
  logic [1:0]       o_fwd_b;
  logic             o_md_timeout;
  logic [CNT_W-1:0] o_stall_count;

  modport master (
    output i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt,
           i_ex_rs, i_ex_rt, i_ex_rd, i_ex_memread, i_ex_muldiv, i_branch_taken,
           i_mem_rd, i_mem_regwrite, i_wb_rd, i_wb_regwrite,
           i_muldiv_done, i_stat_clr,
    input  o_stall_if, o_stall_id, o_stall_ex, o_bubble_ex, o_flush_id,
           o_fwd_a, o_fwd_b, o_md_timeout, o_stall_count
  );

  modport slave (
    input  i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt,
           i_ex_rs, i_ex_rt, i_ex_rd, i_ex_memread, i_ex_muldiv, i_branch_taken,
           i_mem_rd, i_mem_regwrite, i_wb_rd, i_wb_regwrite,
           i_muldiv_done, i_stat_clr,
    output o_stall_if, o_stall_id, o_stall_ex, o_bubble_ex, o_flush_id,
           o_fwd_a, o_fwd_b, o_md_timeout, o_stall_count
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// EX operand forward select: EX/MEM result beats MEM/WB, $0 never forwards.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] i_src,
  input  logic [RA_W-1:0] i_mem_rd,
  input  logic            i_mem_we,
  input  logic [RA_W-1:0] i_wb_rd,
  input  logic            i_wb_we,
  output logic [1:0]      o_sel
);

  // priority compare of the two in-flight destinations against the source
  always_comb begin
    o_sel = FWD_RF;
    if (i_mem_we && (i_mem_rd != '0) && (i_mem_rd == i_src))
      o_sel = FWD_MEM;
    else if (i_wb_we && (i_wb_rd != '0) && (i_wb_rd == i_src))
      o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use and
// mult/div stalls, branch flush, EX forwarding selects, stall statistics.
//
//  state       | meaning
//  ------------+--------------------------------------------------------
//  ST_RUN      | normal issue; branch flush or load-use stall per cycle
//  ST_MD_BUSY  | mult/div in flight, front end and EX held, timer running
//  ST_MD_DRAIN | result writes HI/LO, one bubble into EX, then ST_RUN
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W       = RA_W_DEF,
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  localparam int                TMR_W    = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(MD_TIMEOUT - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic             r_md_timeout;
  logic [CNT_W-1:0] r_stall_count;
  logic             w_lu;
  logic             w_md_start;
  logic             w_md_expire;
  ctrl_t            w_ctrl;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  hazard_ctrl_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .i_src    (bus.i_ex_rs),
    .i_mem_rd (bus.i_mem_rd),
    .i_mem_we (bus.i_mem_regwrite),
    .i_wb_rd  (bus.i_wb_rd),
    .i_wb_we  (bus.i_wb_regwrite),
    .o_sel    (w_fwd_a)
  );

  hazard_ctrl_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .i_src    (bus.i_ex_rt),
    .i_mem_rd (bus.i_mem_rd),
    .i_mem_we (bus.i_mem_regwrite),
    .i_wb_rd  (bus.i_wb_rd),
    .i_wb_we  (bus.i_wb_regwrite),
    .o_sel    (w_fwd_b)
  );

  assign w_lu = bus.i_ex_memread && (bus.i_ex_rd != '0) &&
                ((bus.i_id_use_rs && (bus.i_ex_rd == bus.i_id_rs)) ||
                 (bus.i_id_use_rt && (bus.i_ex_rd == bus.i_id_rt)));

  assign w_md_start  = (r_state == ST_RUN) && bus.i_ex_muldiv && !bus.i_branch_taken;
  // Timer counts down from MD_TIMEOUT-1; reaching zero in MD_BUSY without
  // done means this is the MD_TIMEOUT-th busy cycle.
  assign w_md_expire = (r_state == ST_MD_BUSY) && !bus.i_muldiv_done && (r_timer == '0);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:      if (w_md_start) w_state_nxt = ST_MD_BUSY;
      ST_MD_BUSY:  if (bus.i_muldiv_done) w_state_nxt = ST_MD_DRAIN;
                   else if (w_md_expire)  w_state_nxt = ST_RUN;
      ST_MD_DRAIN: w_state_nxt = ST_RUN;
      default:     w_state_nxt = ST_RUN;
    endcase
  end

  // output decode; branch flush takes precedence over a coincident load-use
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      ST_RUN: begin
        if (bus.i_branch_taken) begin
          w_ctrl.flush_id  = 1'b1;
          w_ctrl.bubble_ex = 1'b1;
        end else if (w_lu) begin
          w_ctrl.stall_if  = 1'b1;
          w_ctrl.stall_id  = 1'b1;
          w_ctrl.bubble_ex = 1'b1;
        end
      end
      ST_MD_BUSY: begin
        w_ctrl.stall_if = 1'b1;
        w_ctrl.stall_id = 1'b1;
        w_ctrl.stall_ex = 1'b1;
      end
      ST_MD_DRAIN: begin
        w_ctrl.stall_if  = 1'b1;
        w_ctrl.stall_id  = 1'b1;
        w_ctrl.bubble_ex = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  // mult/div watchdog down-counter, armed as the op enters EX
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_timer <= '0;
    else if (w_md_start)
      r_timer <= TMR_LOAD;
    else if ((r_state == ST_MD_BUSY) && (r_timer != '0))
      r_timer <= r_timer - 1'b1;
  end

  // sticky timeout flag, only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_md_timeout <= 1'b0;
    else if (w_md_expire) r_md_timeout <= 1'b1;
  end

  // saturating count of front-end stall cycles; clear beats increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_stall_count <= '0;
    else if (bus.i_stat_clr)
      r_stall_count <= '0;
    else if (w_ctrl.stall_if && (r_stall_count != '1))
      r_stall_count <= r_stall_count + 1'b1;
  end

  // a taken branch can only resolve while the pipeline is issuing
  always @(posedge clk) begin
    if (!reset && (r_state != ST_RUN))
      assert (!bus.i_branch_taken);
  end

  assign bus.o_stall_if    = !reset && w_ctrl.stall_if;
  assign bus.o_stall_id    = !reset && w_ctrl.stall_id;
  assign bus.o_stall_ex    = !reset && w_ctrl.stall_ex;
  assign bus.o_bubble_ex   = !reset && w_ctrl.bubble_ex;
  assign bus.o_flush_id    = !reset && w_ctrl.flush_id;
  assign bus.o_fwd_a       = reset ? FWD_RF : w_fwd_a;
  assign bus.o_fwd_b       = reset ? FWD_RF : w_fwd_b;
  assign bus.o_md_timeout  = r_md_timeout;
  assign bus.o_stall_count = r_stall_count;

endmodule
